// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: opcodes, function codes,
// datapath select/ALU encodings, state codes and the decoded-instruction record.
package multi_cycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  typedef enum logic [1:0] {
    PC_NEXT = 2'b00,
    PC_REL  = 2'b01,
    PC_ABS  = 2'b10,
    PC_HALT = 2'b11
  } pcSel_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_OR  = 3'b011,
    ALU_AND = 3'b100,
    ALU_SLT = 3'b101
  } aluOp_t;

  localparam logic SRCA_RS   = 1'b0;
  localparam logic SRCA_SA   = 1'b1;
  localparam logic SRCB_RT   = 1'b0;
  localparam logic SRCB_IMMD = 1'b1;
  localparam logic DB_ALU    = 1'b0;
  localparam logic DB_DM     = 1'b1;
  localparam logic REGDST_RT = 1'b0;
  localparam logic REGDST_RD = 1'b1;
  localparam logic EXT_ZERO  = 1'b0;
  localparam logic EXT_SIGN  = 1'b1;

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_IMM, CL_LW, CL_SW, CL_BR, CL_J, CL_HALT, CL_UNDEF
  } instClass_t;

  typedef enum logic [1:0] {BR_EQ, BR_NE, BR_GTZ, BR_NONE} brKind_t;

  typedef struct packed {
    instClass_t cls;
    brKind_t    br;
    logic       aluSrcA;
    logic       aluSrcB;
    logic       db;
    logic       regDst;
    logic       extSel;
    aluOp_t     aluOp;
  } decode_t;

  // BGTZ only looks at the sign flag; a zero result counts as taken.
  function automatic logic brTaken(brKind_t kind, logic zero, logic sign);
    case (kind)
      BR_EQ:   return zero;
      BR_NE:   return !zero;
      BR_GTZ:  return !sign;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Pure combinational instruction decode: Op/Func -> instruction class and
// datapath select values.
module mc_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  output decode_t    dec
);

  always_comb begin
    dec = '{cls: CL_UNDEF, br: BR_NONE, aluSrcA: SRCA_RS, aluSrcB: SRCB_RT,
            db: DB_ALU, regDst: REGDST_RD, extSel: EXT_SIGN, aluOp: ALU_ADD};
    case (Op)
      OP_RTYPE: begin
        dec.cls = CL_R;
        case (Func)
          FN_ADD: dec.aluOp = ALU_ADD;
          FN_SUB: dec.aluOp = ALU_SUB;
          FN_AND: dec.aluOp = ALU_AND;
          FN_OR:  dec.aluOp = ALU_OR;
          FN_SLT: dec.aluOp = ALU_SLT;
          FN_SLL: begin
            dec.aluOp   = ALU_SLL;
            dec.aluSrcA = SRCA_SA;
          end
          default: dec.aluOp = ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        dec.cls     = CL_IMM;
        dec.aluSrcB = SRCB_IMMD;
        dec.regDst  = REGDST_RT;
      end
      OP_ORI: begin
        dec.cls     = CL_IMM;
        dec.aluSrcB = SRCB_IMMD;
        dec.regDst  = REGDST_RT;
        dec.extSel  = EXT_ZERO;
        dec.aluOp   = ALU_OR;
      end
      OP_LW: begin
        dec.cls     = CL_LW;
        dec.aluSrcB = SRCB_IMMD;
        dec.db      = DB_DM;
        dec.regDst  = REGDST_RT;
      end
      OP_SW: begin
        dec.cls     = CL_SW;
        dec.aluSrcB = SRCB_IMMD;
      end
      OP_BEQ: begin
        dec.cls   = CL_BR;
        dec.br    = BR_EQ;
        dec.aluOp = ALU_SUB;
      end
      OP_BNE: begin
        dec.cls   = CL_BR;
        dec.br    = BR_NE;
        dec.aluOp = ALU_SUB;
      end
      OP_BGTZ: begin
        dec.cls   = CL_BR;
        dec.br    = BR_GTZ;
        dec.aluOp = ALU_SUB;
      end
      OP_J:    dec.cls = CL_J;
      OP_HALT: dec.cls = CL_HALT;
      default: dec.cls = CL_UNDEF;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU sequencer: IF/ID/EXE/MEM/WB state machine, per-state enables,
// PC select and a retired-instruction counter.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             ZERO,
  input  logic             SIGN,
  output logic             IRWre,
  output logic             PCWre,
  output logic [1:0]       PCSel,
  output logic             RegWr,
  output logic             nRD,
  output logic             nWR,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             DB,
  output logic             RegDst,
  output logic             ExtSel,
  output logic [2:0]       ALUop,
  output logic [2:0]       State,
  output logic             Halted,
  output logic [CNT_W-1:0] RetireCnt
);

  state_t  state, nextState;
  decode_t dec;
  pcSel_t  pcSel;
  logic    irWre, pcWre, regWr, nRd, nWr;

  mc_decode uDecode (
    .Op  (Op),
    .Func(Func),
    .dec (dec)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IF;
      RetireCnt <= '0;
    end else begin
      state <= nextState;
      if (pcWre) RetireCnt <= RetireCnt + CNT_W'(1);
    end
  end

  // Raw Moore enables; pcWre marks the final state of each instruction.
  always_comb begin
    nextState = ST_IF;
    irWre     = 1'b0;
    pcWre     = 1'b0;
    regWr     = 1'b0;
    nRd       = 1'b1;
    nWr       = 1'b1;
    pcSel     = PC_NEXT;
    case (state)
      ST_IF: begin
        nextState = ST_ID;
        irWre     = 1'b1;
      end
      ST_ID: begin
        case (dec.cls)
          CL_J: begin
            nextState = ST_IF;
            pcWre     = 1'b1;
            pcSel     = PC_ABS;
          end
          CL_HALT: nextState = ST_HALT;
          default: nextState = ST_EXE;
        endcase
      end
      ST_EXE: begin
        case (dec.cls)
          CL_LW, CL_SW:  nextState = ST_MEM;
          CL_R, CL_IMM:  nextState = ST_WB;
          default: begin
            nextState = ST_IF;
            pcWre     = 1'b1;
            pcSel     = brTaken(dec.br, ZERO, SIGN) ? PC_REL : PC_NEXT;
          end
        endcase
      end
      ST_MEM: begin
        if (dec.cls == CL_LW) begin
          nextState = ST_WB;
          nRd       = 1'b0;
        end else begin
          nextState = ST_IF;
          nWr       = (dec.cls == CL_SW) ? 1'b0 : 1'b1;
          pcWre     = 1'b1;
        end
      end
      ST_WB: begin
        nextState = ST_IF;
        regWr     = 1'b1;
        pcWre     = 1'b1;
      end
      ST_HALT: begin
        nextState = ST_HALT;
        pcSel     = PC_HALT;
      end
      default: nextState = ST_IF;
    endcase
  end

  // Reset must kill every side effect in the same cycle it is asserted.
  assign IRWre   = irWre & ~RST;
  assign PCWre   = pcWre & ~RST;
  assign RegWr   = regWr & ~RST;
  assign nRD     = nRd | RST;
  assign nWR     = nWr | RST;
  assign PCSel   = pcSel;
  assign ALUSrcA = dec.aluSrcA;
  assign ALUSrcB = dec.aluSrcB;
  assign DB      = dec.db;
  assign RegDst  = dec.regDst;
  assign ExtSel  = dec.extSel;
  assign ALUop   = dec.aluOp;
  assign State   = state;
  assign Halted  = (state == ST_HALT);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-instruction state sequences, enables,
// PC select, decode selects, halt, mid-instruction reset and counter wrap.
module tb_multi_cycle_ctrl;
  import multi_cycle_ctrl_pkg::*;

  logic CLK = 1'b0, RST = 1'b1;
  logic [5:0] Op = '0, Func = '0;
  logic ZERO = 1'b0, SIGN = 1'b0;

  logic IRWre, PCWre, RegWr, nRD, nWR, ALUSrcA, ALUSrcB, DB, RegDst, ExtSel, Halted;
  logic [1:0] PCSel;
  logic [2:0] ALUop, State;
  logic [31:0] RetireCnt;

  logic w4IRWre, w4PCWre, w4RegWr, w4nRD, w4nWR, w4SrcA, w4SrcB, w4DB, w4RegDst, w4Ext, w4Halted;
  logic [1:0] w4PCSel;
  logic [2:0] w4ALUop, w4State;
  logic [3:0] w4Cnt;

  multi_cycle_ctrl dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Func(Func), .ZERO(ZERO), .SIGN(SIGN),
    .IRWre(IRWre), .PCWre(PCWre), .PCSel(PCSel), .RegWr(RegWr), .nRD(nRD), .nWR(nWR),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DB(DB), .RegDst(RegDst), .ExtSel(ExtSel),
    .ALUop(ALUop), .State(State), .Halted(Halted), .RetireCnt(RetireCnt)
  );

  multi_cycle_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .Op(Op), .Func(Func), .ZERO(ZERO), .SIGN(SIGN),
    .IRWre(w4IRWre), .PCWre(w4PCWre), .PCSel(w4PCSel), .RegWr(w4RegWr), .nRD(w4nRD), .nWR(w4nWR),
    .ALUSrcA(w4SrcA), .ALUSrcB(w4SrcB), .DB(w4DB), .RegDst(w4RegDst), .ExtSel(w4Ext),
    .ALUop(w4ALUop), .State(w4State), .Halted(w4Halted), .RetireCnt(w4Cnt)
  );

  always #5 CLK = ~CLK;

  int nCmp = 0, nErr = 0;
  logic [31:0] expRet = '0;

  // {State, IRWre, PCWre, RegWr, nRD, nWR}
  localparam logic [7:0] V_IF    = 8'b000_10011;
  localparam logic [7:0] V_ID    = 8'b001_00011;
  localparam logic [7:0] V_IDL   = 8'b001_01011;
  localparam logic [7:0] V_EXE   = 8'b010_00011;
  localparam logic [7:0] V_EXEL  = 8'b010_01011;
  localparam logic [7:0] V_LWMEM = 8'b011_00001;
  localparam logic [7:0] V_SWMEM = 8'b011_01010;
  localparam logic [7:0] V_WB    = 8'b100_01111;

  function automatic logic [7:0] obs();
    return {State, IRWre, PCWre, RegWr, nRD, nWR};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    nCmp++; if (obs() !== 8'b000_00011) begin nErr++; $display("FAIL reset_enables got %b exp %b", obs(), 8'b000_00011); end
    nCmp++; if (RetireCnt !== 32'd0 || w4Cnt !== 4'd0) begin nErr++; $display("FAIL reset_cnt got %0d/%0d exp 0", RetireCnt, w4Cnt); end
    nCmp++; if (Halted !== 1'b0) begin nErr++; $display("FAIL reset_halted got %b exp 0", Halted); end
    RST = 1'b0; #1;
    nCmp++; if (obs() !== V_IF) begin nErr++; $display("FAIL reset_release got %b exp %b", obs(), V_IF); end
    expRet = 0;
  endtask

  task automatic test_add();
    logic [7:0] v [5] = '{V_IF, V_ID, V_EXE, V_WB, V_IF};
    Op = OP_RTYPE; Func = FN_ADD; #1;
    for (int i = 0; i < 5; i++) begin
      nCmp++; if (obs() !== v[i]) begin nErr++; $display("FAIL add_cyc%0d got %b exp %b", i, obs(), v[i]); end
      if (i == 2) begin
        nCmp++; if (ALUop !== ALU_ADD || RegDst !== REGDST_RD) begin nErr++; $display("FAIL add_sel got op=%b dst=%b exp op=000 dst=1", ALUop, RegDst); end
      end
      if (i == 3) begin
        nCmp++; if (PCSel !== PC_NEXT) begin nErr++; $display("FAIL add_pcsel got %b exp %b", PCSel, PC_NEXT); end
        expRet++;
      end
      if (i < 4) tick();
    end
    nCmp++; if (RetireCnt !== expRet) begin nErr++; $display("FAIL add_retire got %0d exp %0d", RetireCnt, expRet); end
  endtask

  task automatic test_lw_sw();
    logic [7:0] vl [6] = '{V_IF, V_ID, V_EXE, V_LWMEM, V_WB, V_IF};
    logic [7:0] vs [5] = '{V_IF, V_ID, V_EXE, V_SWMEM, V_IF};
    Op = OP_LW; #1;
    for (int i = 0; i < 6; i++) begin
      nCmp++; if (obs() !== vl[i]) begin nErr++; $display("FAIL lw_cyc%0d got %b exp %b", i, obs(), vl[i]); end
      if (i == 4) expRet++;
      if (i < 5) tick();
    end
    Op = OP_SW; #1;
    for (int i = 0; i < 5; i++) begin
      nCmp++; if (obs() !== vs[i]) begin nErr++; $display("FAIL sw_cyc%0d got %b exp %b", i, obs(), vs[i]); end
      if (i == 3) begin
        nCmp++; if (PCSel !== PC_NEXT) begin nErr++; $display("FAIL sw_pcsel got %b exp %b", PCSel, PC_NEXT); end
        expRet++;
      end
      if (i < 4) tick();
    end
    nCmp++; if (RetireCnt !== expRet) begin nErr++; $display("FAIL lwsw_retire got %0d exp %0d", RetireCnt, expRet); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [5]  = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BGTZ, OP_BGTZ};
    logic       zs [5]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ss [5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] exps [5] = '{PC_REL, PC_NEXT, PC_REL, PC_NEXT, PC_REL};
    logic [7:0] v [4]    = '{V_IF, V_ID, V_EXEL, V_IF};
    for (int k = 0; k < 5; k++) begin
      Op = ops[k]; ZERO = zs[k]; SIGN = ss[k]; #1;
      for (int i = 0; i < 4; i++) begin
        nCmp++; if (obs() !== v[i]) begin nErr++; $display("FAIL br%0d_cyc%0d got %b exp %b", k, i, obs(), v[i]); end
        if (i == 2) begin
          nCmp++; if (PCSel !== exps[k] || ALUop !== ALU_SUB) begin nErr++; $display("FAIL br%0d_pcsel got sel=%b op=%b exp sel=%b op=001", k, PCSel, ALUop, exps[k]); end
          expRet++;
        end
        if (i < 3) tick();
      end
      nCmp++; if (RetireCnt !== expRet) begin nErr++; $display("FAIL br%0d_retire got %0d exp %0d", k, RetireCnt, expRet); end
    end
    ZERO = 1'b0; SIGN = 1'b0;
  endtask

  task automatic test_jump_undef();
    logic [7:0] vj [3] = '{V_IF, V_IDL, V_IF};
    logic [7:0] vu [4] = '{V_IF, V_ID, V_EXEL, V_IF};
    Op = OP_J; #1;
    for (int i = 0; i < 3; i++) begin
      nCmp++; if (obs() !== vj[i]) begin nErr++; $display("FAIL j_cyc%0d got %b exp %b", i, obs(), vj[i]); end
      if (i == 1) begin
        nCmp++; if (PCSel !== PC_ABS) begin nErr++; $display("FAIL j_pcsel got %b exp %b", PCSel, PC_ABS); end
        expRet++;
      end
      if (i < 2) tick();
    end
    Op = 6'b111110; #1;
    for (int i = 0; i < 4; i++) begin
      nCmp++; if (obs() !== vu[i]) begin nErr++; $display("FAIL undef_cyc%0d got %b exp %b", i, obs(), vu[i]); end
      if (i == 2) begin
        nCmp++; if (PCSel !== PC_NEXT) begin nErr++; $display("FAIL undef_pcsel got %b exp %b", PCSel, PC_NEXT); end
        expRet++;
      end
      if (i < 3) tick();
    end
    nCmp++; if (RetireCnt !== expRet) begin nErr++; $display("FAIL jundef_retire got %0d exp %0d", RetireCnt, expRet); end
  endtask

  task automatic test_decode();
    // {ALUSrcA, ALUSrcB, DB, RegDst, ExtSel}
    logic [5:0] ops [6]  = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_ORI, OP_ADDI, OP_LW};
    logic [5:0] fns [6]  = '{FN_SLL, FN_SUB, 6'b111111, 6'd0, 6'd0, 6'd0};
    logic [4:0] sels [6] = '{5'b10011, 5'b00011, 5'b00011, 5'b01000, 5'b01001, 5'b01101};
    logic [2:0] alus [6] = '{ALU_SLL, ALU_SUB, ALU_ADD, ALU_OR, ALU_ADD, ALU_ADD};
    for (int k = 0; k < 6; k++) begin
      int n;
      Op = ops[k]; Func = fns[k]; #1;
      tick();
      nCmp++;
      if ({ALUSrcA, ALUSrcB, DB, RegDst, ExtSel} !== sels[k] || ALUop !== alus[k]) begin
        nErr++;
        $display("FAIL dec%0d got sel=%b alu=%b exp sel=%b alu=%b", k, {ALUSrcA, ALUSrcB, DB, RegDst, ExtSel}, ALUop, sels[k], alus[k]);
      end
      n = 0;
      while (State !== ST_IF && n < 8) begin tick(); n++; end
      expRet++;
      nCmp++; if (State !== ST_IF || RetireCnt !== expRet) begin nErr++; $display("FAIL dec%0d_retire got st=%0d cnt=%0d exp st=0 cnt=%0d", k, State, RetireCnt, expRet); end
    end
    Func = '0;
  endtask

  task automatic test_reset_mid();
    Op = OP_LW; #1;
    tick(); tick(); tick();
    nCmp++; if (obs() !== V_LWMEM) begin nErr++; $display("FAIL rstlw_pre got %b exp %b", obs(), V_LWMEM); end
    RST = 1'b1; #1;
    nCmp++; if (nRD !== 1'b1 || PCWre !== 1'b0 || IRWre !== 1'b0) begin nErr++; $display("FAIL rstlw_during got nRD=%b PCWre=%b IRWre=%b exp 1/0/0", nRD, PCWre, IRWre); end
    tick();
    nCmp++; if (State !== ST_IF || RetireCnt !== 32'd0) begin nErr++; $display("FAIL rstlw_after got st=%0d cnt=%0d exp 0/0", State, RetireCnt); end
    RST = 1'b0; expRet = 0;
    Op = OP_RTYPE; Func = FN_ADD; #1;
    tick(); tick(); tick();
    nCmp++; if (obs() !== V_WB) begin nErr++; $display("FAIL rstadd_pre got %b exp %b", obs(), V_WB); end
    RST = 1'b1; #1;
    nCmp++; if (RegWr !== 1'b0 || PCWre !== 1'b0) begin nErr++; $display("FAIL rstadd_during got RegWr=%b PCWre=%b exp 0/0", RegWr, PCWre); end
    tick();
    nCmp++; if (State !== ST_IF || RetireCnt !== 32'd0) begin nErr++; $display("FAIL rstadd_after got st=%0d cnt=%0d exp 0/0", State, RetireCnt); end
    RST = 1'b0; #1;
  endtask

  task automatic test_halt();
    Op = OP_HALT; #1;
    tick();
    nCmp++; if (obs() !== V_ID) begin nErr++; $display("FAIL halt_id got %b exp %b", obs(), V_ID); end
    tick();
    for (int i = 0; i < 12; i++) begin
      nCmp++;
      if (State !== ST_HALT || Halted !== 1'b1 || PCWre !== 1'b0 || PCSel !== PC_HALT || RetireCnt !== expRet) begin
        nErr++;
        $display("FAIL halt_cyc%0d got st=%0d h=%b pcw=%b sel=%b cnt=%0d exp 5/1/0/11/%0d", i, State, Halted, PCWre, PCSel, RetireCnt, expRet);
      end
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0; #1;
    nCmp++; if (State !== ST_IF || Halted !== 1'b0 || RetireCnt !== 32'd0) begin nErr++; $display("FAIL halt_reset got st=%0d h=%b cnt=%0d exp 0/0/0", State, Halted, RetireCnt); end
    expRet = 0;
  endtask

  task automatic test_wrap();
    Op = OP_J; #1;
    for (int k = 1; k <= 16; k++) begin
      tick(); tick();
      if (k == 15) begin
        nCmp++; if (w4Cnt !== 4'd15) begin nErr++; $display("FAIL wrap_15 got %0d exp 15", w4Cnt); end
      end
    end
    nCmp++; if (w4Cnt !== 4'd0 || RetireCnt !== 32'd16) begin nErr++; $display("FAIL wrap_16 got w4=%0d w32=%0d exp 0/16", w4Cnt, RetireCnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_sw();
    test_branch();
    test_jump_undef();
    test_decode();
    test_reset_mid();
    test_halt();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d compares", nCmp);
    $fatal(1, "timeout");
  end

endmodule
